iterative_unrotator: RTL and testbench
======================================

ITERATIVE_UNROTATOR -- requirements
Module: iterative_unrotator

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port data_i  input  N  rotated word to be restored.
REQ-005 SHALL have port shift_amount_i  input  $clog2(N)  rotation amount originally applied.
REQ-006 SHALL have port shift_direction_i  input  1  original direction: 0 = rotated left, 1 = rotated right.
REQ-007 SHALL have port valid_i  input  1  upstream word valid.
REQ-008 SHALL have port ready_o  output  1  block can accept a word.
REQ-009 SHALL have port data_o  output  N  restored word.
REQ-010 SHALL have port valid_o  output  1  data_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts data_o.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = 1 only in IDLE, valid_o = 1 only in DONE.
REQ-013 SHALL accept on clk edge with valid_i && ready_o: capture data_i into work register, amount into down-counter, direction into register.
REQ-014 SHALL transition IDLE->BUSY on accept with amount != 0; IDLE->DONE on accept with amount == 0 (work register = data_i).
REQ-015 SHALL in BUSY rotate work register one bit per cycle opposite to captured direction (dir 0 -> rotate right by 1, dir 1 -> rotate left by 1) and decrement counter.
REQ-016 SHALL transition BUSY->DONE on the cycle the counter's final step completes; latency accept-edge to valid_o high = amount+1 cycles (amount 0 -> 1 cycle).
REQ-017 SHALL hold data_o and valid_o stable in DONE until ready_i is high; DONE->IDLE on valid_o && ready_i.
REQ-018 SHALL ignore valid_i and all data inputs while in BUSY or DONE (no back-to-back accept on the DONE handshake edge).
REQ-019 SHALL drive data_o from the work register in all states; content outside DONE is don't-care for consumers.
REQ-020 SHALL treat amount N-1 as maximum; no wrap beyond N-1 rotation steps.

Reset
REQ-021 SHALL on rst_n low immediately force state IDLE, work register 0, counter 0, direction 0; thus data_o = 0, valid_o = 0, ready_o = 1.
REQ-022 SHALL abandon any in-flight word on reset mid-BUSY or mid-DONE; no output produced for it.
REQ-023 SHALL accept first word no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-024 SHALL honour macro UNROTATOR_SHORT_PATH_EN: when defined, on accept with amount > N/2 the block rotates the captured direction's same way by N-amount steps (shortest path), latency = min(amount, N-amount)+1; when undefined, latency is always amount+1 per REQ-016. Final data_o identical in both builds.

Structure
REQ-025 SHALL place the FSM state enum typedef (IDLE, BUSY, DONE) and the default width constant in package iterative_unrotator_pkg.
REQ-026 SHALL use one combinational sub-module rotate_one_step (inputs word, direction; output word rotated by one) instantiated in the datapath.

Verification
REQ-027 SHALL cover: N=8, data_i=8'b10000111, amount 3, dir 0, ready_i=1 -> data_o=8'b11110000, valid_o high 4 cycles after accept edge (without UNROTATOR_SHORT_PATH_EN).
REQ-028 SHALL cover: data_i=8'b00011110, amount 3, dir 1 -> data_o=8'b11110000; amount 0 with data_i=8'hA5 -> data_o=8'hA5 after 1 cycle.
REQ-029 SHALL cover: backpressure, ready_i=0 for 5 cycles in DONE -> data_o/valid_o stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next edge.
REQ-030 SHALL cover: rst_n low mid-BUSY (amount 7) -> valid_o=0, data_o=0, ready_o=1 asynchronously; next word processes correctly.
REQ-031 SHALL cover: exhaustive 2 dirs x 8 amounts on data 8'b11110000 pre-rotated by bench -> every output equals 8'b11110000; with UNROTATOR_SHORT_PATH_EN, amount 7 latency = 2 cycles.

Source files
------------

// File: rtl/iterative_unrotator_pkg.sv
// Shared definitions for the iterative unrotator: FSM state encoding and
// the default data width.
package iterative_unrotator_pkg;

  // Default data width in bits (power of two, at least 4).
  localparam int unsigned DEFAULT_N = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } unrot_state_e;

endpackage

// File: rtl/iterative_unrotator_rotate_one_step.sv
// Combinational single-bit rotator used by the unrotator datapath.
// dir_i = 0 rotates right by one bit, dir_i = 1 rotates left by one bit.
module rotate_one_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] word_i,
  input  logic         dir_i,
  output logic [N-1:0] word_o
);

  // Select between a one-bit left and a one-bit right rotation.
  always_comb begin
    word_o = word_i;
    if (dir_i == 1'b1) begin
      word_o = {word_i[N-2:0], word_i[N-1]};
    end else begin
      word_o = {word_i[0], word_i[N-1:1]};
    end
  end

endmodule

// File: rtl/iterative_unrotator.sv
// Iterative unrotator: accepts a word that was rotated by shift_amount_i in
// shift_direction_i and restores it one bit per clock, with valid/ready
// handshakes on both sides.
// Optional build macro: UNROTATOR_SHORT_PATH_EN -- when defined, amounts
// above N/2 are undone by rotating the original way by N-amount steps.
module iterative_unrotator
  import iterative_unrotator_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         data_i,
  input  logic [$clog2(N)-1:0] shift_amount_i,
  input  logic                 shift_direction_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [N-1:0]         data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  unrot_state_e  state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // dir_q holds the direction of the original rotation as seen by the
  // stepper: steps always go opposite to dir_q.
  logic          dir_q, dir_d;

  logic [N-1:0]  step_word_s;
  logic [CW-1:0] start_cnt_s;
  logic          start_dir_s;

`ifdef UNROTATOR_SHORT_PATH_EN
  localparam logic [CW-1:0] HALF_N = CW'(N / 2);
  logic take_short_s;

  // Pick the shorter way round: N-amount steps in the original direction.
  // The stored direction is inverted so the stepper's "opposite" rotation
  // becomes the original direction. N-amount is formed modulo 2**CW,
  // which equals N because N is a power of two.
  always_comb begin
    take_short_s = (shift_amount_i > HALF_N);
    if (take_short_s) begin
      start_cnt_s = CNT_ZERO - shift_amount_i;
      start_dir_s = ~shift_direction_i;
    end else begin
      start_cnt_s = shift_amount_i;
      start_dir_s = shift_direction_i;
    end
  end
`else
  // Always undo the rotation step by step in the opposite direction.
  always_comb begin
    start_cnt_s = shift_amount_i;
    start_dir_s = shift_direction_i;
  end
`endif

  // dir_q = 0 (originally rotated left) makes the stepper rotate right.
  rotate_one_step #(
    .N(N)
  ) u_step (
    .word_i(work_q),
    .dir_i (dir_q),
    .word_o(step_word_s)
  );

  // Next-state and datapath update for the accept / step / hand-off FSM.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          work_d = data_i;
          cnt_d  = start_cnt_s;
          dir_d  = start_dir_s;
          if (start_cnt_s == CNT_ZERO) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        work_d = step_word_s;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // No new accept on the hand-off edge; IDLE is entered first.
        if (ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= {N{1'b0}};
      cnt_q   <= CNT_ZERO;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign data_o  = work_q;

endmodule

// File: tb/tb_iterative_unrotator.sv
// Scoreboard bench for iterative_unrotator (N = 8). Stimulus pushes the
// expected word and latency at accept; a negedge monitor compares whenever
// valid_o is high. Honours UNROTATOR_SHORT_PATH_EN for expected latency.
module tb_iterative_unrotator;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] data_i = 8'h00;
  logic [2:0]   shift_amount_i = 3'd0;
  logic         shift_direction_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [N-1:0] data_o;
  logic         valid_o;
  logic         ready_i = 1'b1;

  iterative_unrotator #(.N(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_i           (data_i),
    .shift_amount_i   (shift_amount_i),
    .shift_direction_i(shift_direction_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   seen_first = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] w, int k);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] rotr(logic [7:0] w, int k);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < k; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  function automatic int exp_lat(int amt);
`ifdef UNROTATOR_SHORT_PATH_EN
    if (amt > N / 2) return N - amt + 1;
    return amt + 1;
`else
    return amt + 1;
`endif
  endfunction

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: valid_o=1 with data 0x%0h, expected no output", data_o);
      end else begin
        chk("data_o", data_o, sb_q[0].data);
        chk("ready_o_in_done", ready_o, 0);
        if (!seen_first) begin
          seen_first = 1'b1;
          chk("latency", cyc - sb_q[0].acc_cyc + 1, sb_q[0].lat);
        end
        if (ready_i) begin
          void'(sb_q.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, int amt, logic dir, logic [7:0] exp_d);
    exp_t e;
    int   n;
    n = 0;
    while (!ready_o && n < 50) begin
      step();
      n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", ready_o, 1);
    end else begin
      data_i = d;
      shift_amount_i = 3'(amt);
      shift_direction_i = dir;
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      e.data = exp_d;
      e.lat = exp_lat(amt);
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready_o && sb_q.size() == 0) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("idle_timeout", ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base;
    base = 8'b11110000;

    // Reset state.
    #3;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_ready_o", ready_o, 1);
    chk("reset_data_o", data_o, 8'h00);
    #10;
    rst_n = 1'b1;
    step();

    // Directed vectors.
    ready_i = 1'b1;
    send(8'b10000111, 3, 1'b0, 8'b11110000);
    wait_idle();
    send(8'b00011110, 3, 1'b1, 8'b11110000);
    wait_idle();
    send(8'hA5, 0, 1'b0, 8'hA5);
    wait_idle();

    // Backpressure in DONE with competing valid_i.
    ready_i = 1'b0;
    send(8'b00111100, 2, 1'b1, 8'b11110000);
    for (int i = 0; i < 20 && !valid_o; i++) step();
    chk("bp_reach_done", valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      data_i = 8'h5A;
      shift_amount_i = 3'd1;
      shift_direction_i = 1'b0;
      valid_i = 1'b1;
      step();
      chk("bp_valid_held", valid_o, 1);
      chk("bp_ready_low", ready_o, 0);
      chk("bp_data_held", data_o, 8'b11110000);
    end
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("bp_to_idle_ready", ready_o, 1);
    chk("bp_to_idle_valid", valid_o, 0);
    wait_idle();

    // Reset mid-BUSY with amount 7.
    send(8'h3C, 7, 1'b0, rotr(8'h3C, 7));
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", valid_o, 0);
    chk("rst_async_data", data_o, 8'h00);
    chk("rst_async_ready", ready_o, 1);
    sb_q.delete();
    seen_first = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    send(8'b11000011, 2, 1'b0, 8'b11110000);
    wait_idle();

    // Exhaustive directions and amounts on a pre-rotated pattern.
    for (int dir = 0; dir < 2; dir++) begin
      for (int amt = 0; amt < N; amt++) begin
        if (dir == 0) send(rotl(base, amt), amt, 1'b0, base);
        else          send(rotr(base, amt), amt, 1'b1, base);
        wait_idle();
      end
    end

    wait_idle();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
